// File: rtl/boot_sequencer_pkg.sv
// rtl/boot_sequencer_pkg.sv - state encodings, constants and address helper for boot_sequencer
package boot_sequencer_pkg;

  localparam int WORD_STRIDE = 4;
  localparam int CSUM_W      = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  // One cycle after the final handshake while its write is still on the port.
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_VERIFY = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * 32'(WORD_STRIDE);
  endfunction

endpackage

// File: rtl/boot_checksum.sv
// rtl/boot_checksum.sv - clearable 32-bit wrapping additive accumulator
module boot_checksum
  import boot_sequencer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_clear,
  input  logic              i_add_en,
  input  logic [CSUM_W-1:0] i_data,
  output logic [CSUM_W-1:0] o_sum
);

  logic [CSUM_W-1:0] r_sum;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add_en) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - streams a program into instruction memory, then runs the CPU for a bounded time
// Optional read-back checksum verify stage: define BOOT_SEQUENCER_VERIFY_EN.
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int          IMEM_WORDS = 128,
  parameter int          RUN_CYCLES = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'd0
) (
  input  logic                              i_clk,
  input  logic                              i_arst_n,
  input  logic                              i_start,
  input  logic                              i_load_valid,
  input  logic [31:0]                       i_load_data,
  input  logic                              i_load_last,
  input  logic                              i_halt,
  input  logic [31:0]                       i_rdata_ext,
  output logic                              o_load_ready,
  output logic [31:0]                       o_addr_ext,
  output logic                              o_wen_ext,
  output logic                              o_ren_ext,
  output logic [31:0]                       o_wdata_ext,
  output logic                              o_cpu_enable,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_error,
  output logic [$clog2(IMEM_WORDS+1)-1:0]   o_words_loaded
);

  localparam int WL_W = $clog2(IMEM_WORDS + 1);
  localparam int RC_W = $clog2(RUN_CYCLES + 1);
  localparam logic [WL_W-1:0] WORDS_LAST = WL_W'(IMEM_WORDS - 1);
  localparam logic [RC_W-1:0] RUN_LAST   = RC_W'(RUN_CYCLES - 1);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_wen;
  logic            r_cpu_en;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic [WL_W-1:0] r_words;
  logic [RC_W-1:0] r_run_cnt;

  logic w_accept;
  logic w_run_end;
  logic w_enter_load;
  logic w_addr_restart;
  logic w_addr_step;
  logic w_verify_end;
  logic w_verify_ok;

  assign w_accept     = (r_state == ST_LOAD) && i_load_valid;
  assign w_run_end    = i_halt || (r_run_cnt == RUN_LAST);
  assign w_enter_load = (w_next == ST_LOAD) && (r_state != ST_LOAD);

`ifdef BOOT_SEQUENCER_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;

  logic              r_ren;
  logic              r_rd_pend;
  logic [WL_W-1:0]   r_rd_idx;
  logic              w_rd_more;
  logic [CSUM_W-1:0] w_load_sum;
  logic [CSUM_W-1:0] w_rb_sum;

  assign w_rd_more      = (r_rd_idx + 1'b1) != r_words;
  assign w_addr_restart = (r_state == ST_DRAIN);
  assign w_addr_step    = r_ren && w_rd_more;
  // Last read data arrives the cycle after the final read; fold it in combinationally.
  assign w_verify_end   = r_rd_pend && !r_ren;
  assign w_verify_ok    = (w_rb_sum + i_rdata_ext) == w_load_sum;

  boot_checksum u_load_sum (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_clear  (w_enter_load),
    .i_add_en (w_accept),
    .i_data   (i_load_data),
    .o_sum    (w_load_sum)
  );

  boot_checksum u_rb_sum (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_clear  (w_addr_restart),
    .i_add_en (r_rd_pend),
    .i_data   (i_rdata_ext),
    .o_sum    (w_rb_sum)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_ren     <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_idx  <= '0;
    end else begin
      r_rd_pend <= r_ren;
      if (r_state == ST_DRAIN) begin
        r_ren    <= 1'b1;
        r_rd_idx <= '0;
      end else if (r_ren) begin
        r_ren    <= w_rd_more;
        r_rd_idx <= r_rd_idx + 1'b1;
      end
    end
  end

  assign o_ren_ext = r_ren;
`else
  localparam bit VERIFY_EN = 1'b0;

  logic w_unused_rdata;
  assign w_unused_rdata = ^i_rdata_ext;
  assign w_addr_restart = 1'b0;
  assign w_addr_step    = 1'b0;
  assign w_verify_end   = 1'b0;
  assign w_verify_ok    = 1'b0;
  assign o_ren_ext      = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_start) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_accept) begin
          if (i_load_last)              w_next = ST_DRAIN;
          else if (r_words == WORDS_LAST) w_next = ST_ERROR;
        end
      end
      ST_DRAIN:  w_next = VERIFY_EN ? ST_VERIFY : ST_RUN;
      ST_VERIFY: if (w_verify_end) w_next = w_verify_ok ? ST_RUN : ST_ERROR;
      ST_RUN:    if (w_run_end) w_next = ST_DONE;
      ST_ERROR:  w_next = ST_ERROR;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wen     <= 1'b0;
      r_cpu_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_words   <= '0;
      r_run_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_wen    <= w_accept;
      r_cpu_en <= (w_next == ST_RUN);
      r_done   <= (w_next == ST_DONE);
      r_error  <= (w_next == ST_ERROR);
      r_busy   <= !((w_next == ST_IDLE) || (w_next == ST_DONE) || (w_next == ST_ERROR));

      if (w_accept) begin
        r_wdata <= i_load_data;
        r_addr  <= word_addr(BASE_ADDR, 32'(r_words));
      end else if (w_addr_restart) begin
        r_addr  <= BASE_ADDR;
      end else if (w_addr_step) begin
        r_addr  <= r_addr + 32'(WORD_STRIDE);
      end

      if (w_enter_load)  r_words <= '0;
      else if (w_accept) r_words <= r_words + 1'b1;

      if (r_state == ST_RUN) r_run_cnt <= r_run_cnt + 1'b1;
      else                   r_run_cnt <= '0;
    end
  end

  assign o_load_ready   = (r_state == ST_LOAD);
  assign o_addr_ext     = r_addr;
  assign o_wen_ext      = r_wen;
  assign o_wdata_ext    = r_wdata;
  assign o_cpu_enable   = r_cpu_en;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_words;

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Sequences start-up of the single-cycle CPU: streams a program into instruction memory through the external write port, optionally reads it back and checks it, then drives the CPU `enable` input for a bounded run. Sits between the test/host interface and the `cpu` top, and owns `addr_ext`/`wen_ext`/`ren_ext`/`wdata_ext` and `enable`.

## Interface
- `IMEM_WORDS`, 128: instruction memory capacity in 32-bit words.
- `RUN_CYCLES`, 1024: maximum cycles `cpu_enable` is held high.
- `BASE_ADDR`, 0: byte address of the first loaded word.
- `clk` in 1: single clock.
- `arst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin load; sampled in IDLE and DONE only.
- `load_valid` in 1: load word is valid.
- `load_data` in 32: instruction word.
- `load_last` in 1: marks the final word of the program.
- `halt` in 1: ends RUN early.
- `rdata_ext` in 32: instruction memory read-back data.
- `load_ready` out 1: word accepted when `load_valid && load_ready`.
- `addr_ext` out 32: external instruction memory byte address.
- `wen_ext` out 1: external write enable.
- `ren_ext` out 1: external read enable.
- `wdata_ext` out 32: external write data.
- `cpu_enable` out 1: drives the CPU `enable` input.
- `busy` out 1: high in every state except IDLE, DONE and ERROR.
- `done` out 1: level, high in DONE.
- `error` out 1: level, high in ERROR.
- `words_loaded` out $clog2(IMEM_WORDS+1): count of words accepted.

## Operation
- States and transitions:
  - IDLE: `start` -> LOAD.
  - LOAD: accepted word with `load_last` -> VERIFY (macro defined) or RUN.
  - LOAD: accepted word number `IMEM_WORDS` without `load_last` -> ERROR.
  - VERIFY: all words match -> RUN; any mismatch -> ERROR.
  - RUN: `halt` or cycle count reaches `RUN_CYCLES` -> DONE.
  - DONE: `start` -> LOAD. This reloads; memory is not cleared.
  - ERROR: left only by reset.
- Load handshake:
  - `load_ready` = (state == LOAD).
  - Each accepted word i produces one write cycle: `wen_ext` = 1, `addr_ext` = `BASE_ADDR` + 4·i, `wdata_ext` = word.
- `words_loaded` clears on entry to LOAD and increments per accepted word.
- RUN:
  - `cpu_enable` is high for every RUN cycle.
  - Entry to RUN occurs after the final write has completed.
  - The cycle counter counts cycles with `cpu_enable` high.
- `halt` and the terminal count in the same cycle: go to DONE; `cpu_enable` drops next cycle.
- `start` while busy is ignored.
- All address arithmetic is 32-bit unsigned, stride 4. Addresses never wrap within `IMEM_WORDS`.

## Timing
- Reset values (async assert, sync-free release):
  - State IDLE.
  - `load_ready`, `wen_ext`, `ren_ext`, `cpu_enable`, `busy`, `done`, `error` = 0.
  - `addr_ext`, `wdata_ext`, `words_loaded` = 0.
- All outputs are registered except `load_ready`, which decodes directly from the state register.
- A handshake in cycle n gives `wen_ext` high in cycle n+1. Back-to-back words give one write per cycle.
- `start` in cycle n gives `load_ready` high in cycle n+1.
- Last write in cycle n:
  - Without the macro, `cpu_enable` is high from cycle n+1.
  - With the macro, VERIFY starts in cycle n+1.
- `cpu_enable` high-time is exactly `RUN_CYCLES` cycles unless `halt` is asserted. `halt` sampled high in cycle n gives `cpu_enable` low in cycle n+1.
- Reset mid-operation aborts immediately. Any in-flight write is dropped; memory contents are undefined for that word.

## Configuration
- `BOOT_SEQUENCER_VERIFY_EN` defined:
  - VERIFY state is present.
  - Issues `ren_ext` with `addr_ext` = `BASE_ADDR` + 4·i for i = 0..`words_loaded`-1, one per cycle.
  - Each `rdata_ext` is compared one cycle after its read against a 32-bit wrapping additive checksum accumulated during LOAD.
  - Read-back sum ≠ load sum after the final word -> ERROR. Otherwise -> RUN.
- Undefined: VERIFY, the checksum logic and `ren_ext` are absent. `ren_ext` is tied 0.

## Structure
- Package `boot_sequencer_pkg`:
  - State enum: IDLE, LOAD, VERIFY, RUN, DONE, ERROR.
  - `WORD_STRIDE` = 4.
  - Checksum width constant.
- One sub-module, `boot_checksum`: clearable 32-bit wrapping accumulator with add-enable. Instantiated twice under the macro (load sum, read-back sum).

## Test plan
- Reset during LOAD after 3 words -> all outputs return to reset values immediately; `start` then begins a new load with `words_loaded` = 0.
- Load 4 words 0x20010005, 0x20020003, 0x00221820, 0xAC030000 with the last flagged, `RUN_CYCLES` = 8 -> writes to addresses 0,4,8,12; `cpu_enable` high exactly 8 cycles; `done` = 1; CPU data memory word 0 reads 8.
- `load_valid` toggling every other cycle -> one write per accepted word; no writes in gap cycles; addresses contiguous.
- Load 128 words without `load_last` -> `error` = 1; `cpu_enable` never asserts; `load_ready` = 0 afterwards.
- `halt` asserted on the 3rd RUN cycle -> `cpu_enable` high exactly 3 cycles; `done` = 1; `start` in DONE reloads.
- Macro defined, host overwrites word 2 via an external write during VERIFY setup (forced mismatch) -> `error` = 1, `cpu_enable` stays 0. Clean load passes VERIFY in `words_loaded`+1 cycles.
